// File: rtl/uart_pkg.sv
// Shared types, ASCII constants and baud helper for the ASCII-binary UART receiver.
// Build option: UART_RX_PARITY_EN adds an even-parity bit after the data bits.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StWaitHigh
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StStop, StWaitHigh
    } rx_state_e;
`endif

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_1  = 8'h31;
    localparam logic [7:0] CH_LF = 8'h0a;
    localparam logic [7:0] CH_CR = 8'h0d;

    function automatic int unsigned clks_per_bit(input int unsigned f_clk,
                                                 input int unsigned baud);
        return f_clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx2.sv
// Synchroniser plus byte FSM: 8N1 (or 8E1 with UART_RX_PARITY_EN) UART deserialiser.
module uart_rx2
    import uart_pkg::*;
#(
    parameter int unsigned F_CLK     = 50_000_000,
    parameter int unsigned UART_BAUD = 921600
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_DATA,
    output logic [7:0] RX_BYTE,
    output logic       RX_DV,
    output logic       FRAME_ERR,
    output logic       PAR_ERR
);
    localparam int unsigned CPB = clks_per_bit(F_CLK, UART_BAUD);
    localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] HALF = CW'(CPB / 2);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    logic            rx_meta_q, rx_sync_q;
    rx_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            dv_q, dv_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            perr_q, perr_d;
    logic            pbad_q, pbad_d;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            pbad_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX_DATA;
            rx_sync_q <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            pbad_q    <= pbad_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
        pbad_d  = pbad_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                pbad_d = 1'b0;
`endif
                if (!rx_sync_q) state_d = StStart;
            end
            StStart: begin
                // Re-check at mid start bit so short low glitches are discarded.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == 3'd7) state_d = StParity;
`else
                    if (bit_q == 3'd7) state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = StStop;
                    if (rx_sync_q != ^shift_q) begin
                        perr_d = 1'b1;
                        pbad_d = 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                // Leave at mid-stop so a start bit immediately following is caught.
                if (cnt_q == LAST) begin
                    if (rx_sync_q) begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (!pbad_q) begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                        end
`else
                        byte_d = shift_q;
                        dv_d   = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign RX_BYTE   = byte_q;
    assign RX_DV     = dv_q;
    assign FRAME_ERR = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign PAR_ERR   = perr_q;
`else
    assign PAR_ERR   = 1'b0;
`endif

endmodule

// File: rtl/uart_bin_line_rx.sv
// Receives UART bytes and parses '\n'-terminated lines of ASCII '0'/'1' into a binary word.
// Build option: UART_RX_PARITY_EN (passed through to the byte receiver).
module uart_bin_line_rx
    import uart_pkg::*;
#(
    parameter int unsigned F_CLK     = 50_000_000,
    parameter int unsigned UART_BAUD = 921600,
    parameter int unsigned WIDTH     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             RX_DATA,
    output logic [7:0]       RX_BYTE,
    output logic             RX_DV,
    output logic [WIDTH-1:0] LINE_VALUE,
    output logic             LINE_DV,
    output logic             LINE_ERR,
    output logic             FRAME_ERR,
    output logic             PAR_ERR
);
    localparam int unsigned CNTW = $clog2(WIDTH + 2);

    logic [7:0]       rx_byte;
    logic             rx_dv, frame_err, par_err;
    logic [WIDTH-1:0] acc_q, acc_d, value_q, value_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             bad_q, bad_d, ovf_q, ovf_d;
    logic             line_dv_q, line_dv_d, line_err_q, line_err_d;

    uart_rx2 #(
        .F_CLK     (F_CLK),
        .UART_BAUD (UART_BAUD)
    ) u_rx (
        .CLK       (CLK),
        .RST       (RST),
        .RX_DATA   (RX_DATA),
        .RX_BYTE   (rx_byte),
        .RX_DV     (rx_dv),
        .FRAME_ERR (frame_err),
        .PAR_ERR   (par_err)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q      <= '0;
            value_q    <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            ovf_q      <= 1'b0;
            line_dv_q  <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            value_q    <= value_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            ovf_q      <= ovf_d;
            line_dv_q  <= line_dv_d;
            line_err_q <= line_err_d;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        value_d    = value_q;
        cnt_d      = cnt_q;
        bad_d      = bad_q | frame_err | par_err;
        ovf_d      = ovf_q;
        line_dv_d  = 1'b0;
        line_err_d = 1'b0;
        if (rx_dv) begin
            if (rx_byte == CH_0 || rx_byte == CH_1) begin
                acc_d = {acc_q[WIDTH-2:0], rx_byte[0]};
                if (cnt_q <= CNTW'(WIDTH)) cnt_d = cnt_q + 1'b1;
                if (cnt_q >= CNTW'(WIDTH)) ovf_d = 1'b1;
            end else if (rx_byte == CH_CR) begin
                acc_d = acc_q;
            end else if (rx_byte == CH_LF) begin
                if (bad_q || ovf_q) begin
                    line_err_d = 1'b1;
                end else if (cnt_q != '0) begin
                    value_d   = acc_q;
                    line_dv_d = 1'b1;
                end
                acc_d = '0;
                cnt_d = '0;
                bad_d = 1'b0;
                ovf_d = 1'b0;
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    assign RX_BYTE    = rx_byte;
    assign RX_DV      = rx_dv;
    assign FRAME_ERR  = frame_err;
    assign PAR_ERR    = par_err;
    assign LINE_VALUE = value_q;
    assign LINE_DV    = line_dv_q;
    assign LINE_ERR   = line_err_q;

endmodule

// File: tb/tb_uart_bin_line_rx.sv
// Scoreboard bench for uart_bin_line_rx: expected events queued at drive time, checked on pulses.
module tb_uart_bin_line_rx;
    localparam int CPB = 50_000_000 / 921600;
    localparam int K_BYTE = 0, K_LINE = 1, K_LERR = 2, K_FERR = 3, K_PERR = 4, K_NONE = 9;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RX_DATA = 1'b1;
    logic [7:0]  RX_BYTE;
    logic        RX_DV;
    logic [15:0] LINE_VALUE;
    logic        LINE_DV, LINE_ERR, FRAME_ERR, PAR_ERR;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } evt_t;
    evt_t exp_q[$];

    int          n_total = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned last_dv_cyc = 0;

    uart_bin_line_rx #(
        .F_CLK      (50_000_000),
        .UART_BAUD  (921600),
        .WIDTH      (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_DATA    (RX_DATA),
        .RX_BYTE    (RX_BYTE),
        .RX_DV      (RX_DV),
        .LINE_VALUE (LINE_VALUE),
        .LINE_DV    (LINE_DV),
        .LINE_ERR   (LINE_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .PAR_ERR    (PAR_ERR)
    );

    always #10 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [15:0] val);
        evt_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [15:0] val);
        evt_t e;
        check_eq("evt_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("evt_kind", kind, e.kind);
            check_eq("evt_val", val, e.val);
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge CLK) begin
        if (!RST) begin
            if (RX_DV) begin
                last_dv_cyc = cyc;
                take(K_BYTE, {8'h00, RX_BYTE});
            end
            if (FRAME_ERR) take(K_FERR, 16'h0);
            if (PAR_ERR) take(K_PERR, 16'h0);
            if (LINE_DV) begin
                check_eq("line_latency", cyc, last_dv_cyc + 1);
                take(K_LINE, LINE_VALUE);
            end
            if (LINE_ERR) begin
                check_eq("lerr_latency", cyc, last_dv_cyc + 1);
                take(K_LERR, 16'h0);
            end
        end
    end

    task automatic bit_time(input logic v, input int n);
        RX_DATA = v;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_ok);
        bit_time(1'b0, CPB);
        for (int i = 0; i < 8; i++) bit_time(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        bit_time((^b) ^ ~par_ok, CPB);
`endif
        bit_time(stop_bit, CPB);
        RX_DATA = 1'b1;
    endtask

    // Queues a byte event per character and the line outcome after a trailing '\n'.
    task automatic send_str(input string s, input int line_kind, input logic [15:0] line_val);
        for (int i = 0; i < s.len(); i++) begin
            push(K_BYTE, {8'h00, s[i]});
            if (s[i] == 8'h0a && line_kind != K_NONE) push(line_kind, line_val);
            send_byte(s[i], 1'b1, 1'b1);
        end
    endtask

    initial begin
        repeat (120000) @(posedge CLK);
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        logic [7:0] b31;
        b31 = 8'h31;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst_rx_byte", RX_BYTE, 0);
        check_eq("rst_rx_dv", RX_DV, 0);
        check_eq("rst_line_value", LINE_VALUE, 0);
        check_eq("rst_line_dv", LINE_DV, 0);
        check_eq("rst_line_err", LINE_ERR, 0);
        check_eq("rst_frame_err", FRAME_ERR, 0);
        check_eq("rst_par_err", PAR_ERR, 0);
        bit_time(1'b1, 2 * CPB);

        send_str("101\n", K_LINE, 16'h0005);
        send_str("1111000011110000\r\n", K_LINE, 16'hf0f0);
        send_str("\n", K_NONE, 16'h0);
        bit_time(1'b1, CPB);
        check_eq("value_f0f0", LINE_VALUE, 16'hf0f0);

        s = "";
        for (int i = 0; i < 17; i++) s = {s, "1"};
        s = {s, "\n"};
        send_str(s, K_LERR, 16'h0);
        bit_time(1'b1, CPB);
        check_eq("value_kept_ovf", LINE_VALUE, 16'hf0f0);
        send_str("1\n", K_LINE, 16'h0001);

        send_str("1x0\n", K_LERR, 16'h0);
        bit_time(1'b1, CPB);
        check_eq("value_kept_bad", LINE_VALUE, 16'h0001);

        push(K_FERR, 16'h0);
        send_byte(8'h41, 1'b0, 1'b1);
        bit_time(1'b1, CPB);
        push(K_FERR, 16'h0);
        bit_time(1'b0, 20 * CPB);
        bit_time(1'b1, 2 * CPB);
        send_str("\n", K_LERR, 16'h0);
        send_str("0\n", K_LINE, 16'h0000);

        bit_time(1'b0, 10);
        bit_time(1'b1, 3 * CPB);

        // Partial line then reset part-way through bit 4 of 0x31.
        send_str("1", K_NONE, 16'h0);
        bit_time(1'b0, CPB);
        for (int i = 0; i < 4; i++) bit_time(b31[i], CPB);
        bit_time(b31[4], CPB / 2);
        RX_DATA = 1'b1;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("rst2_line_value", LINE_VALUE, 0);
        check_eq("rst2_rx_byte", RX_BYTE, 0);
        bit_time(1'b1, 2 * CPB);
        send_str("10\n", K_LINE, 16'h0002);

`ifdef UART_RX_PARITY_EN
        push(K_PERR, 16'h0);
        send_byte(8'h31, 1'b1, 1'b0);
        bit_time(1'b1, CPB);
        send_str("\n", K_LERR, 16'h0);
        send_str("1", K_NONE, 16'h0);
        bit_time(1'b1, CPB);
        check_eq("par_rx_byte", RX_BYTE, 8'h31);
`endif

        bit_time(1'b1, 4 * CPB);
        check_eq("exp_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
